// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache.
// Connects the MEM stage (word reads and byte-enabled writes) to a block memory.
// The block memory has no busywait, so every block request is held for MEM_LATENCY cycles.
module data_cache_controller #(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned MEM_LATENCY = 16
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         CPU_READ,
  input  logic         CPU_WRITE,
  input  logic [31:0]  CPU_ADDRESS,
  input  logic [31:0]  CPU_WRITEDATA,
  input  logic [3:0]   CPU_BYTEEN,
  output logic [31:0]  CPU_READDATA,
  output logic         CPU_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 28 - IDX_W;
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addr_tag;
  logic [1:0]       word_sel;
  logic             req, hit, wr_hit, fill_done;
  logic [31:0]      hit_word;
  logic [127:0]     wr_mask, wr_val;
  logic             unused_addr_lsb;

  // Address fields and hit detection; both-high request is treated as no request.
  assign idx             = CPU_ADDRESS[4 +: IDX_W];
  assign addr_tag        = CPU_ADDRESS[31 -: TAG_W];
  assign word_sel        = CPU_ADDRESS[3:2];
  assign req             = CPU_READ ^ CPU_WRITE;
  assign hit             = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign hit_word        = data_q[idx][{word_sel, 5'b00000} +: 32];
  assign wr_val          = {4{CPU_WRITEDATA}};
  assign unused_addr_lsb = ^CPU_ADDRESS[1:0];

  // Byte-lane mask of the selected word within the block.
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < 4; b++) begin
      if (CPU_BYTEEN[b]) wr_mask[{word_sel, 2'(b), 3'b000} +: 8] = 8'hFF;
    end
  end

  // State and latency counter register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and combinational CPU/memory outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    CPU_READDATA  = '0;
    CPU_BUSYWAIT  = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    wr_hit        = 1'b0;
    fill_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (CPU_READ) CPU_READDATA = hit_word;
            else          wr_hit       = 1'b1;
          end else begin
            CPU_BUSYWAIT = 1'b1;
            cnt_d        = '0;
            state_d      = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        CPU_BUSYWAIT  = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = data_q[idx];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ALLOCATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ALLOCATE: begin
        CPU_BUSYWAIT = 1'b1;
        MEM_READ     = 1'b1;
        MEM_ADDRESS  = CPU_ADDRESS[31:4];
        if (cnt_q == CNT_LAST) begin
          fill_done = 1'b1;
          cnt_d     = '0;
          state_d   = UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        CPU_BUSYWAIT = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line status bits; only these are cleared by reset.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays: block fill on allocate, byte merge on write hit.
  always_ff @(posedge CLOCK) begin
    if (fill_done) begin
      data_q[idx] <= MEM_READDATA;
      tag_q[idx]  <= addr_tag;
    end else if (wr_hit) begin
      data_q[idx] <= (data_q[idx] & ~wr_mask) | (wr_val & wr_mask);
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed testbench for data_cache_controller with a read-data scoreboard
// and a static block-memory model that answers every fill address.
module tb_data_cache_controller;

  localparam int unsigned ML     = 16;
  localparam int unsigned BUDGET = 200;

  logic         CLOCK, RESET;
  logic         CPU_READ, CPU_WRITE;
  logic [31:0]  CPU_ADDRESS, CPU_WRITEDATA, CPU_READDATA;
  logic [3:0]   CPU_BYTEEN;
  logic         CPU_BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  int           busy_n, mrd_n, mwr_n, both_n, stray_n, first_rd, last_wr, wait_n;
  logic [27:0]  mrd_addr, mwr_addr;
  logic [127:0] mwr_data;
  logic [31:0]  done_rdata;

  data_cache_controller #(.NUM_SETS(8), .MEM_LATENCY(ML)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE), .CPU_ADDRESS(CPU_ADDRESS),
    .CPU_WRITEDATA(CPU_WRITEDATA), .CPU_BYTEEN(CPU_BYTEEN),
    .CPU_READDATA(CPU_READDATA), .CPU_BUSYWAIT(CPU_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Memory contents: block 0x4 is preloaded, every other block is a pattern of its address.
  function automatic logic [127:0] blk(input logic [27:0] a);
    logic [127:0] b;
    if (a == 28'h4) b = {32'h13, 32'h12, 32'h11, 32'h10};
    else for (int k = 0; k < 4; k++) b[32*k +: 32] = {4'hB, a} ^ 32'(k);
    return b;
  endfunction

  function automatic logic [31:0] blk_word(input logic [27:0] a, input int k);
    logic [127:0] b;
    b = blk(a);
    return b[32*k +: 32];
  endfunction

  assign MEM_READDATA = blk(MEM_ADDRESS);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one CPU request, hold it through the stall, record memory activity,
  // and compare read data against the scoreboard when the stall ends.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    logic [31:0] exp_v;
    @(negedge CLOCK);
    CPU_READ = rd; CPU_WRITE = wr; CPU_ADDRESS = addr;
    CPU_WRITEDATA = wdata; CPU_BYTEEN = be;
    #1;
    busy_n = 0; mrd_n = 0; mwr_n = 0; both_n = 0; stray_n = 0;
    first_rd = -1; last_wr = -1;
    mrd_addr = '0; mwr_addr = '0; mwr_data = '0;
    while (CPU_BUSYWAIT && busy_n < int'(BUDGET)) begin
      if (MEM_READ)  begin mrd_n++; mrd_addr = MEM_ADDRESS; if (first_rd < 0) first_rd = busy_n; end
      if (MEM_WRITE) begin mwr_n++; mwr_addr = MEM_ADDRESS; mwr_data = MEM_WRITEDATA; last_wr = busy_n; end
      if (MEM_READ && MEM_WRITE) both_n++;
      if (!MEM_READ && !MEM_WRITE && (MEM_ADDRESS != '0 || MEM_WRITEDATA != '0)) stray_n++;
      busy_n++;
      @(negedge CLOCK); #1;
    end
    chk({tag, "_busy_timeout"}, 128'(CPU_BUSYWAIT), 128'(0));
    if (MEM_READ || MEM_WRITE || MEM_ADDRESS != '0 || MEM_WRITEDATA != '0) stray_n++;
    done_rdata = CPU_READDATA;
    if (rd && !wr) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk({tag, "_rdata"}, 128'(CPU_READDATA), 128'(exp_v));
    end
    @(posedge CLOCK); #1;
    CPU_READ = 1'b0; CPU_WRITE = 1'b0; CPU_ADDRESS = '0;
    CPU_WRITEDATA = '0; CPU_BYTEEN = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; CPU_READ = 1'b0; CPU_WRITE = 1'b0;
    CPU_ADDRESS = '0; CPU_WRITEDATA = '0; CPU_BYTEEN = '0;
    repeat (2) @(negedge CLOCK);
    #1;
    chk("rst_busy",     128'(CPU_BUSYWAIT), 128'(0));
    chk("rst_mem_read", 128'(MEM_READ),     128'(0));
    chk("rst_mem_write",128'(MEM_WRITE),    128'(0));
    chk("rst_mem_addr", 128'(MEM_ADDRESS),  128'(0));
    chk("rst_mem_wdata",MEM_WRITEDATA,      128'(0));
    chk("rst_rdata",    128'(CPU_READDATA), 128'(0));
    // Everything misses while reset holds the lines invalid.
    CPU_READ = 1'b1; CPU_ADDRESS = 32'h48; #1;
    chk("rst_busy_req", 128'(CPU_BUSYWAIT), 128'(1));
    chk("rst_mem_read_req", 128'(MEM_READ), 128'(0));
    CPU_READ = 1'b0; CPU_ADDRESS = '0;
    @(negedge CLOCK); RESET = 1'b0;

    // Cold read miss; stall count excludes the request cycle itself.
    exp_q.push_back(32'h12);
    access("cold", 1'b1, 1'b0, 32'h48, 32'h0, 4'h0);
    chk("cold_stall",  128'(busy_n - 1), 128'(ML + 1));
    chk("cold_mrd_n",  128'(mrd_n),      128'(ML));
    chk("cold_mrd_addr", 128'(mrd_addr), 128'(28'h4));
    chk("cold_mwr_n",  128'(mwr_n),      128'(0));
    chk("cold_stray",  128'(stray_n),    128'(0));

    // Full-word write hit, then read back.
    access("wr_hit", 1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 4'hF);
    chk("wr_hit_busy", 128'(busy_n), 128'(0));
    chk("wr_hit_mem",  128'(mrd_n + mwr_n + stray_n), 128'(0));
    exp_q.push_back(32'hDEADBEEF);
    access("rd_44a", 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    chk("rd_44a_busy", 128'(busy_n), 128'(0));

    // Single-byte write merges into lane 1.
    access("wr_byte", 1'b0, 1'b1, 32'h44, 32'h0000AA00, 4'b0010);
    exp_q.push_back(32'hDEADAAEF);
    access("rd_44b", 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);

    // Zero byte enables leave data untouched.
    access("wr_be0", 1'b0, 1'b1, 32'h48, 32'hFFFFFFFF, 4'b0000);
    chk("wr_be0_busy", 128'(busy_n), 128'(0));
    exp_q.push_back(32'h12);
    access("rd_48", 1'b1, 1'b0, 32'h48, 32'h0, 4'h0);

    // Illegal read+write on a hit address and on a miss address.
    access("ill_hit", 1'b1, 1'b1, 32'h44, 32'h11111111, 4'hF);
    chk("ill_hit_busy",  128'(busy_n), 128'(0));
    chk("ill_hit_rdata", 128'(done_rdata), 128'(0));
    chk("ill_hit_mem",   128'(mrd_n + mwr_n + stray_n), 128'(0));
    access("ill_miss", 1'b1, 1'b1, 32'h3000, 32'h22222222, 4'hF);
    chk("ill_miss_busy", 128'(busy_n), 128'(0));
    chk("ill_miss_mem",  128'(mrd_n + mwr_n + stray_n), 128'(0));
    exp_q.push_back(32'hDEADAAEF);
    access("rd_44c", 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    exp_q.push_back(32'h10);
    access("rd_40", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);

    // Dirty conflict miss: write-back of the victim, then fill.
    exp_q.push_back(blk_word(28'hC, 1));
    access("dirty", 1'b1, 1'b0, 32'hC4, 32'h0, 4'h0);
    chk("dirty_mwr_n",    128'(mwr_n),    128'(ML));
    chk("dirty_mwr_addr", 128'(mwr_addr), 128'(28'h4));
    chk("dirty_mwr_w1",   128'(mwr_data[63:32]), 128'(32'hDEADAAEF));
    chk("dirty_mwr_blk",  mwr_data, {32'h13, 32'h12, 32'hDEADAAEF, 32'h10});
    chk("dirty_mrd_n",    128'(mrd_n),    128'(ML));
    chk("dirty_mrd_addr", 128'(mrd_addr), 128'(28'hC));
    chk("dirty_order",    128'(first_rd), 128'(last_wr + 1));
    chk("dirty_both",     128'(both_n),   128'(0));
    chk("dirty_stall",    128'(busy_n - 1), 128'(2 * ML + 1));

    // Reset five cycles into a fill, between clock edges.
    @(negedge CLOCK);
    CPU_READ = 1'b1; CPU_ADDRESS = 32'h248; #1;
    wait_n = 0;
    while (!MEM_READ && wait_n < int'(BUDGET)) begin @(negedge CLOCK); #1; wait_n++; end
    chk("midrst_fill_start", 128'(MEM_READ), 128'(1));
    repeat (4) @(negedge CLOCK);
    #2; RESET = 1'b1; #1;
    chk("midrst_mem_read", 128'(MEM_READ),    128'(0));
    chk("midrst_mem_addr", 128'(MEM_ADDRESS), 128'(0));
    chk("midrst_busy",     128'(CPU_BUSYWAIT), 128'(1));
    @(negedge CLOCK);
    CPU_READ = 1'b0; CPU_ADDRESS = '0; #1;
    RESET = 1'b0;
    exp_q.push_back(blk_word(28'h24, 2));
    access("refill", 1'b1, 1'b0, 32'h248, 32'h0, 4'h0);
    chk("refill_mrd_n",    128'(mrd_n),    128'(ML));
    chk("refill_mrd_addr", 128'(mrd_addr), 128'(28'h24));
    chk("refill_mwr_n",    128'(mwr_n),    128'(0));
    chk("refill_stall",    128'(busy_n - 1), 128'(ML + 1));
    chk("sb_drained",      128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
